// File: rtl/sid_bus_initiator.sv
// sid_bus_initiator: buffers host register requests in a small FIFO and
// issues at most one chip-select access per SID bus cycle (phi2_tick) on
// the cs/we/oe bus of the SID core.
// Build option: define SID_BUS_READ_EN to execute read requests. Without
// it, reads are accepted and dropped at pop, and the read strobe and
// response outputs are tied low.
module sid_bus_initiator #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       res,
    input  logic       phi2_tick,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [4:0] req_addr,
    input  logic [7:0] req_data,
    output logic       bus_cs,
    output logic       bus_we,
    output logic       bus_oe,
    output logic [4:0] bus_addr,
    output logic [7:0] bus_data,
    input  logic [7:0] bus_data_i,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
    } req_t;

`ifdef SID_BUS_READ_EN
    typedef enum logic [2:0] {ST_IDLE, ST_ARMED, ST_DRIVE, ST_CAPTURE, ST_RECOVER} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_ARMED, ST_DRIVE, ST_RECOVER} state_t;
`endif

    req_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    req_t             head;
    logic             push;
    logic             issue;
    logic             drop;
    logic             pop;

    state_t           state_q;
    logic             bus_cs_q;
    logic             bus_we_q;
    logic [4:0]       bus_addr_q;
    logic [7:0]       bus_data_q;
`ifdef SID_BUS_READ_EN
    logic             bus_oe_q;
    logic             rsp_valid_q;
    logic [7:0]       rsp_data_q;
`endif

    // Handshake, head-of-queue decode and next pointer/fill values
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        head      = fifo_mem[rd_ptr_q];
        req_ready = (count_q < CNT_W'(FIFO_DEPTH));
        push      = req_valid && req_ready;
        issue     = 1'b0;
        drop      = 1'b0;
        if (state_q == ST_ARMED && count_q != '0) begin
`ifdef SID_BUS_READ_EN
            issue = phi2_tick;
`else
            // Reads are retired without waiting for a bus cycle.
            issue = phi2_tick && head.we;
            drop  = !head.we;
`endif
        end
        pop      = issue || drop;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Request storage
    // NOTE: the array has no reset; an entry is only read after it was written, and the fill counter is what gets cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {req_we, req_addr, req_data};
        end
    end

    // FIFO pointers and fill counter
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Bus access sequencer with registered strobes and response
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= ST_IDLE;
            bus_cs_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
`ifdef SID_BUS_READ_EN
            bus_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`endif
        end else begin
            bus_cs_q    <= 1'b0;
            bus_we_q    <= 1'b0;
`ifdef SID_BUS_READ_EN
            bus_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) state_q <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (issue) begin
                        bus_addr_q <= head.addr;
                        bus_data_q <= head.data;
                        bus_cs_q   <= 1'b1;
                        bus_we_q   <= head.we;
`ifdef SID_BUS_READ_EN
                        bus_oe_q   <= !head.we;
`endif
                        state_q    <= ST_DRIVE;
                    end else if (drop) begin
                        // Fill after this pop excludes a same-cycle push; IDLE re-arms on it.
                        state_q <= (count_q > CNT_W'(1)) ? ST_ARMED : ST_IDLE;
                    end
                end
                ST_DRIVE: begin
`ifdef SID_BUS_READ_EN
                    state_q <= bus_we_q ? ST_RECOVER : ST_CAPTURE;
`else
                    state_q <= ST_RECOVER;
`endif
                end
`ifdef SID_BUS_READ_EN
                ST_CAPTURE: begin
                    rsp_data_q  <= bus_data_i;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RECOVER;
                end
`endif
                ST_RECOVER: begin
                    state_q <= (count_q != '0) ? ST_ARMED : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_cs   = bus_cs_q;
    assign bus_we   = bus_we_q;
    assign bus_addr = bus_addr_q;
    assign bus_data = bus_data_q;
    assign busy     = (state_q != ST_IDLE) || (count_q != '0);

`ifdef SID_BUS_READ_EN
    assign bus_oe    = bus_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
`else
    logic unused_bus_data;
    assign unused_bus_data = ^bus_data_i;
    assign bus_oe    = 1'b0;
    assign rsp_valid = 1'b0;
    assign rsp_data  = 8'h00;
`endif

endmodule

// File: tb/tb_sid_bus_initiator.sv
// Testbench for sid_bus_initiator: scenario tasks plus randomized traffic,
// each cycle compared against a transaction-level reference model.
module tb_sid_bus_initiator;
    localparam int DEPTH = 8;
`ifdef SID_BUS_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       phi2_tick = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [4:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       bus_cs, bus_we, bus_oe;
    logic [4:0] bus_addr;
    logic [7:0] bus_data;
    logic [7:0] bus_data_i;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;

    always #5 clk = ~clk;

    sid_bus_initiator #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .res(res), .phi2_tick(phi2_tick),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_data(req_data),
        .bus_cs(bus_cs), .bus_we(bus_we), .bus_oe(bus_oe),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_data_i(bus_data_i),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    // SID core register file: registers the addressed byte one clk after bus_oe, noise otherwise
    logic [7:0] core_mem [32];
    logic [7:0] core_q;
    always @(posedge clk) core_q <= bus_oe ? core_mem[bus_addr] : 8'($urandom);
    assign bus_data_i = core_q;

    // Reference model: a queue of accepted requests; the head may use the first
    // tick at or after it is armed; an access keeps the bus for 2 clk (write)
    // or 3 clk (read) after its DRIVE clk begins.
    typedef struct {
        bit         we;
        logic [4:0] addr;
        logic [7:0] data;
        int         pcyc;
    } ent_t;

    ent_t       mq[$];
    ent_t       drv;
    int         cyc = 0;
    int         prev_end = 0;
    int         drive_cyc = -10;
    int         rsp_cyc = -10;
    logic [4:0] m_addr = '0;
    logic [7:0] m_data = '0;
    logic [7:0] m_rsp = '0;
    logic [7:0] rsp_pend = '0;
    logic [26:0] obs, exp_v;
    int tests_run = 0;
    int tests_failed = 0;

    task automatic model_reset();
        mq.delete();
        prev_end  = cyc;
        drive_cyc = -10;
        rsp_cyc   = -10;
        m_addr    = '0;
        m_data    = '0;
        m_rsp     = '0;
        drv.we    = 1'b0;
    endtask

    // One clk: sample DUT, form model expectation, apply inputs, advance model
    task automatic cycle(input bit tk, input bit vld, input bit t_we,
                         input logic [4:0] t_addr, input logic [7:0] t_data, output bit acc);
        bit   m_ready, m_cs, m_busy, m_rv;
        int   armed;
        ent_t h;
        ent_t n;
        @(negedge clk);
        obs = {req_ready, busy, bus_cs, bus_we, bus_oe, bus_addr, bus_data, rsp_valid, rsp_data};
        if (cyc == drive_cyc) begin
            m_addr = drv.addr;
            m_data = drv.data;
        end
        if (cyc == rsp_cyc) m_rsp = rsp_pend;
        m_cs    = (cyc == drive_cyc);
        m_rv    = (cyc == rsp_cyc);
        m_ready = (mq.size() < DEPTH);
        m_busy  = (mq.size() > 0) || (cyc < prev_end);
        exp_v   = {m_ready, m_busy, m_cs, m_cs && drv.we, m_cs && !drv.we && READ_EN,
                   m_addr, m_data, m_rv, m_rsp};
        phi2_tick = tk;
        req_valid = vld;
        req_we    = t_we;
        req_addr  = t_addr;
        req_data  = t_data;
        if (mq.size() > 0) begin
            h = mq[0];
            armed = (h.pcyc + 2 > prev_end) ? h.pcyc + 2 : prev_end;
            if (h.we || READ_EN) begin
                if (tk && cyc >= armed) begin
                    void'(mq.pop_front());
                    drv       = h;
                    drive_cyc = cyc + 1;
                    prev_end  = cyc + 1 + (h.we ? 2 : 3);
                    if (!h.we) begin
                        rsp_cyc  = cyc + 3;
                        rsp_pend = core_mem[h.addr];
                    end
                end
            end else if (cyc >= armed) begin
                void'(mq.pop_front());
                prev_end = cyc + 1;
            end
        end
        acc = vld && m_ready;
        if (acc) begin
            n.we = t_we; n.addr = t_addr; n.data = t_data; n.pcyc = cyc;
            mq.push_back(n);
        end
        cyc++;
    endtask

    task automatic test_reset();
        bit acc;
        bit hit = 1'b0;
        res = 1'b1; phi2_tick = 1'b0; req_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({req_ready, busy, bus_cs, bus_we, bus_oe, bus_addr, bus_data, rsp_valid, rsp_data} !== {1'b1, 26'd0}) begin
            tests_failed++;
            $display("FAIL reset_values: got %h expected %h",
                     {req_ready, busy, bus_cs, bus_we, bus_oe, bus_addr, bus_data, rsp_valid, rsp_data}, {1'b1, 26'd0});
        end
        res = 1'b0;
        model_reset();
        cycle(1'b0, 1'b1, 1'b1, 5'h10, 8'h55, acc);
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 5'h00, 8'h00, acc);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_to_drive cyc=%0d: got %h expected %h", cyc - 1, obs, exp_v);
            end
            if (drive_cyc == cyc - 1) hit = 1'b1;
        end
        tests_run++;
        if (!hit) begin
            tests_failed++;
            $display("FAIL reset_drive_timeout: got no DRIVE expected DRIVE within 20 clk");
        end
        // Reset asserted in the middle of the DRIVE clk
        res = 1'b1; phi2_tick = 1'b0; req_valid = 1'b0;
        #1;
        tests_run++;
        if ({bus_cs, bus_we, bus_oe} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_mid_drive: got strobes %b expected 000", {bus_cs, bus_we, bus_oe});
        end
        @(negedge clk);
        res = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 5'h00, 8'h00, acc);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_after cyc=%0d: got %h expected %h", cyc - 1, obs, exp_v);
            end
        end
    endtask

    task automatic test_single_write();
        bit         acc;
        int         cs_cnt = 0;
        logic [4:0] a_seen = '0;
        logic [7:0] d_seen = '0;
        logic [1:0] weoe_seen = '0;
        for (int i = 0; i < 40; i++) begin
            cycle((i % 16) == 15, i == 0, 1'b1, 5'h18, 8'h0F, acc);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL single_write cyc=%0d: got %h expected %h", cyc - 1, obs, exp_v);
            end
            if (bus_cs) begin
                cs_cnt++;
                a_seen = bus_addr; d_seen = bus_data; weoe_seen = {bus_we, bus_oe};
            end
        end
        tests_run++;
        if (cs_cnt != 1 || a_seen !== 5'h18 || d_seen !== 8'h0F || weoe_seen !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_write_access: got cs=%0d addr=%h data=%h we_oe=%b expected cs=1 addr=18 data=0f we_oe=10",
                     cs_cnt, a_seen, d_seen, weoe_seen);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_write_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_read();
        bit acc;
        int drv_at = -1;
        int rsp_at = -1;
        int pulses = 0;
        int oe_cnt = 0;
`ifdef SID_BUS_READ_EN
        core_mem[5'h1B] = 8'hA5;
        for (int i = 0; i < 40; i++) begin
            cycle((i % 16) == 15, i == 0, 1'b0, 5'h1B, 8'h00, acc);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL read cyc=%0d: got %h expected %h", cyc - 1, obs, exp_v);
            end
            if (bus_cs) drv_at = cyc - 1;
            if (rsp_valid) begin pulses++; rsp_at = cyc - 1; end
        end
        tests_run++;
        if (pulses != 1 || drv_at < 0 || rsp_at - drv_at != 2) begin
            tests_failed++;
            $display("FAIL read_latency: got pulses=%0d delay=%0d expected pulses=1 delay=2", pulses, rsp_at - drv_at);
        end
        tests_run++;
        if (rsp_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL read_data_held: got %h expected a5", rsp_data);
        end
`else
        for (int i = 0; i < 40; i++) begin
            cycle((i % 16) == 15, i < 2, i == 1, (i == 0) ? 5'h19 : 5'h04, (i == 0) ? 8'h00 : 8'h41, acc);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL no_read cyc=%0d: got %h expected %h", cyc - 1, obs, exp_v);
            end
            if (bus_oe) oe_cnt++;
            if (rsp_valid) pulses++;
            if (bus_cs && drv_at < 0) begin
                drv_at = cyc - 1;
                rsp_at = {19'd0, bus_addr, bus_data};
            end
        end
        tests_run++;
        if (oe_cnt != 0 || pulses != 0 || drv_at - (cyc - 40) != 16 || rsp_at != 32'h0441) begin
            tests_failed++;
            $display("FAIL no_read_write: got oe=%0d rsp=%0d drive_at=%0d addr_data=%h expected 0 0 16 0441",
                     oe_cnt, pulses, drv_at - (cyc - 40), rsp_at);
        end
`endif
    endtask

    task automatic test_fill();
        bit         acc;
        bit         done = 1'b0;
        logic [4:0] issued[$];
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 5'(i), 8'($urandom), acc);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL fill cyc=%0d: got %h expected %h", cyc - 1, obs, exp_v);
            end
        end
        cycle(1'b1, 1'b1, 1'b1, 5'd8, 8'h99, acc);
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_full_ready: got %b expected 0", req_ready);
        end
        done = acc;
        for (int i = 0; i < 90; i++) begin
            cycle((i % 4) == 3, !done, 1'b1, 5'd8, 8'h99, acc);
            if (acc) done = 1'b1;
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL fill_drain cyc=%0d: got %h expected %h", cyc - 1, obs, exp_v);
            end
            if (bus_cs) issued.push_back(bus_addr);
        end
        tests_run++;
        if (!done || issued.size() != 9) begin
            tests_failed++;
            $display("FAIL fill_count: got accepted=%b issued=%0d expected accepted=1 issued=9", done, issued.size());
        end
        for (int k = 0; k < issued.size(); k++) begin
            tests_run++;
            if (issued[k] !== 5'(k)) begin
                tests_failed++;
                $display("FAIL fill_order[%0d]: got %h expected %h", k, issued[k], 5'(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int drives[$];
        int min_gap = 1000;
        for (int i = 0; i < 40; i++) begin
            cycle(i >= 4 && (i % 2) == 0, i < 3, 1'b1, 5'(i + 1), 8'(i * 17), acc);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL back_to_back cyc=%0d: got %h expected %h", cyc - 1, obs, exp_v);
            end
            if (bus_cs) drives.push_back(i);
        end
        for (int k = 1; k < drives.size(); k++)
            if (drives[k] - drives[k - 1] < min_gap) min_gap = drives[k] - drives[k - 1];
        tests_run++;
        if (drives.size() != 3 || min_gap < 3) begin
            tests_failed++;
            $display("FAIL back_to_back_spacing: got drives=%0d min_gap=%0d expected drives=3 min_gap>=3",
                     drives.size(), min_gap);
        end
    endtask

    task automatic test_random();
        bit acc;
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom), 8'($urandom), acc);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL random cyc=%0d: got %h expected %h", cyc - 1, obs, exp_v);
            end
        end
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 5'h00, 8'h00, acc);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL random_drain cyc=%0d: got %h expected %h", cyc - 1, obs, exp_v);
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL random_idle: got busy=%b expected 0", busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) core_mem[i] = 8'($urandom);
        test_reset();
        test_single_write();
        test_read();
        test_fill();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sid_bus_initiator.md
# sid_bus_initiator

Bus-side initiator for the SID core register interface. Accepts register write and read requests from a host-side producer, such as a tune player, the MIDI/SPI front end or a CPU shim, and buffers them in a small FIFO. Issues at most one access per SID bus cycle on the chip-select/write-enable/output-enable bus that the SID core responds to. Returns read data from the core's registered data output as a one-cycle response pulse.

## Interface
- FIFO_DEPTH, 8, request FIFO entries; power of two, 2..64
- clk  input  1  system clock
- res  input  1  reset, asynchronous, active-high
- phi2_tick  input  1  one-clk pulse marking the start of a SID bus cycle; ignored while `res`
- req_valid  input  1  request present
- req_ready  output  1  FIFO not full; transfer on `req_valid && req_ready`
- req_we  input  1  1 = write, 0 = read
- req_addr  input  5  SID register address 0x00..0x1F
- req_data  input  8  write data; don't-care for reads
- bus_cs  output  1  chip select to core
- bus_we  output  1  write strobe
- bus_oe  output  1  read strobe
- bus_addr  output  5  register address
- bus_data  output  8  write data
- bus_data_i  input  8  core's registered data output
- rsp_valid  output  1  one-clk pulse; read data valid
- rsp_data  output  8  read data, held until next response
- busy  output  1  FIFO non-empty or access in flight

## Operation
- FIFO entry: {we, addr[4:0], data[7:0]}, 14 bits.
  - Push on `req_valid && req_ready`; pop on entry to DRIVE.
  - Simultaneous push and pop when full: not possible, because `req_ready` depends only on current fill. Push and pop together at fill N: fill stays N.
- `req_ready` = fill < FIFO_DEPTH. Combinational from the fill counter only, not from `req_valid`.
- FSM states:
  - IDLE: FIFO empty. Go to ARMED when fill > 0.
  - ARMED: wait for `phi2_tick`. On the tick, latch the FIFO head into the bus registers, pop, go to DRIVE.
  - DRIVE: exactly one clk.
    - `bus_cs` = 1; `bus_we` = head.we; `bus_oe` = !head.we.
    - Next state is CAPTURE for a read, otherwise RECOVER.
  - CAPTURE: all strobes 0; addr/data held. `rsp_data` <= `bus_data_i` at end of cycle; `rsp_valid` pulses the following clk. Next state is RECOVER.
  - RECOVER: all strobes 0. Go to ARMED if fill > 0, else IDLE.
- `phi2_tick` arriving in DRIVE, CAPTURE or RECOVER is ignored. Each access consumes its own, later tick, so there is at most one access per bus cycle.
- `bus_addr`/`bus_data` change only on entry to DRIVE and hold their value otherwise.
- Reads of any address are issued unchanged. Addresses outside 0x19..0x1C return the core's last bus value; no filtering is applied.
- Writes to 0x19..0x1C are issued unchanged.
- `busy` = (state != IDLE) || fill > 0.

## Timing
- Reset state while `res`, asynchronous, and on its release:
  - state IDLE, FIFO empty, `req_ready` = 1.
  - `bus_cs`/`bus_we`/`bus_oe` = 0; `bus_addr` = 0; `bus_data` = 0.
  - `rsp_valid` = 0; `rsp_data` = 0; `busy` = 0.
- Reset mid-access drops strobes immediately, flushes the FIFO and suppresses any pending `rsp_valid`.
- First-access latency: request accepted at edge T with FIFO empty → ARMED at T+1 → DRIVE begins on the clk after the first `phi2_tick` sampled at or after T+1.
- Read data path: DRIVE at cycle D; core registers data at end of D; sampled at end of D+1 (CAPTURE); `rsp_valid` = 1 in D+2 only.
- Back-to-back accesses require separate `phi2_tick` pulses. Minimum tick spacing is 3 clk for writes and 4 clk for reads; ticks inside that window are ignored as specified above.

## Configuration
- `SID_BUS_READ_EN` defined: read requests are executed as described above.
- Not defined:
  - read requests are accepted and dropped at pop; they consume no tick and take ARMED→IDLE/ARMED directly.
  - `bus_oe`, `rsp_valid` and `rsp_data` are tied to 0.
  - CAPTURE state is removed.

## Test plan
- Reset: assert `res` mid-DRIVE of a write → `bus_cs` = 0 within the same cycle; after release `req_ready` = 1, `busy` = 0, no further strobes.
- Single write {0x18, 0x0F}, tick every 16 clk → exactly one DRIVE clk with `bus_cs` = 1, `bus_we` = 1, `bus_oe` = 0, addr 0x18, data 0x0F; then `busy` = 0.
- Read 0x1B with model returning 0xA5 one clk after `bus_oe` (SID_BUS_READ_EN) → `rsp_valid` single pulse exactly 2 clk after DRIVE, `rsp_data` = 0xA5; held after pulse.
- Fill FIFO with 8 writes, no ticks → `req_ready` = 0 after the 8th. Then give one tick while pushing a 9th → one pop, push accepted; issued order equals push order.
- Ticks at 2-clk spacing with 3 queued writes → only every tick falling in ARMED is used; exactly one DRIVE per used tick; no two DRIVEs closer than 3 clk.
- Build without SID_BUS_READ_EN: queue read 0x19 then write {0x04, 0x41} → no `bus_oe`, no `rsp_valid`; the write is issued on the first tick.
